div_unit: RTL

Multi-cycle 32-bit divider for the single-cycle CPU, covering the DIV/DIVU instructions that the combinational ALU cannot handle in one cycle. Control issues a `start` with two operands. The block then runs restoring shift-subtract division, one quotient bit per clock. It returns the quotient (LO) and remainder (HI) with a one-cycle `done` pulse. The core stalls on `busy` and writes HI/LO when `done` is high.

---
 rtl/cpu31_pkg.sv | 22 ++
 rtl/div_step.sv | 35 +++
 rtl/div_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/cpu31_pkg.sv
// ============================================================================
// Module   : cpu31_pkg
// Brief    : Shared types and constants for the cpu31 multi-cycle divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu31_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam int          DIV_ITERS    = 32;
    localparam logic [31:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// Module   : div_step
// Brief    : One restoring shift-subtract iteration (combinational).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0]   w_shifted;
    logic [WIDTH+1:0] w_trial;
    logic             w_ge;
    logic             w_unused_trial;

    // Extra guard bit keeps the sign of the trial visible even when the
    // shifted remainder itself needs WIDTH+1 bits.
    assign w_shifted      = {rem, quo[WIDTH-1]};
    assign w_trial        = {1'b0, w_shifted} - {2'b00, d};
    assign w_ge           = ~w_trial[WIDTH+1];
    assign w_unused_trial = w_trial[WIDTH];

    assign rem_next = w_ge ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], w_ge};

endmodule

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
// Module   : div_unit
// Brief    : Multi-cycle 32-bit restoring divider (DIV/DIVU), one bit/clock.
//            Signed support is built only when DIV_SIGNED_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_unit
    import cpu31_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    div_state_t       r_state;
    div_state_t       w_state_next;
    logic [5:0]       r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_zero;

    logic             w_accept;
    logic             w_zero;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_fix_q;
    logic [WIDTH-1:0] w_fix_r;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;

    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_zero   = (divisor == '0);

`ifdef DIV_SIGNED_EN
    logic w_sa;
    logic w_sb;
    logic r_neg_q;
    logic r_neg_r;

    assign w_sa    = is_signed & dividend[WIDTH-1];
    assign w_sb    = is_signed & divisor[WIDTH-1];
    assign w_a_mag = w_sa ? -dividend : dividend;
    assign w_b_mag = w_sb ? -divisor  : divisor;
    assign w_fix_q = r_neg_q ? -r_quo : r_quo;
    assign w_fix_r = r_neg_r ? -r_rem : r_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
        end
    end
`else
    logic w_unused_signed;

    assign w_unused_signed = is_signed;
    assign w_a_mag         = dividend;
    assign w_b_mag         = divisor;
    assign w_fix_q         = r_quo;
    assign w_fix_r         = r_rem;
`endif

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (r_rem),
        .quo      (r_quo),
        .d        (r_d),
        .rem_next (w_rem_next),
        .quo_next (w_quo_next)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (start)                 w_state_next = w_zero ? DONE : RUN;
                else if (r_state == DONE)  w_state_next = IDLE;
            end
            RUN:     if (r_cnt == 6'(DIV_ITERS - 1)) w_state_next = FIX;
            FIX:     w_state_next = DONE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_d         <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
        end else if (w_accept) begin
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= w_a_mag;
            r_d        <= w_b_mag;
            r_div_zero <= w_zero;
            // Divide-by-zero skips the iterations, so results land right away.
            if (w_zero) begin
                r_quotient  <= DIV_ZERO_QUO;
                r_remainder <= dividend;
            end
        end else if (r_state == RUN) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt + 6'd1;
        end else if (r_state == FIX) begin
            r_quotient  <= w_fix_q;
            r_remainder <= w_fix_r;
        end
    end

    assign busy      = (r_state == RUN) || (r_state == FIX);
    assign done      = (r_state == DONE);
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign div_zero  = r_div_zero;

endmodule

`default_nettype wire
